// File: rtl/fft_sample_loader.sv
// ----------------------------------------------------------------------------
// fft_sample_loader
//
// Streams one frame of 2^N_LOG2 16-bit FFT input samples into the MCU data
// memory before an FFT run. Samples arrive on a valid/ready handshake and each
// accepted sample is written one cycle later as a half-word to the memory
// write port. Sample k lands at half-word index k (natural order) or at
// rev(k) when the frame should be pre-permuted for an in-place DIT FFT.
//
// Optional feature macro:
//   FFT_LOADER_BITREV_EN  - defined: index = bit-reverse of the sample count
//                           undefined: index = sample count (natural order)
//
// Parameters:
//   N_LOG2     log2 of samples per frame
//   BASE_ADDR  byte address of half-word index 0
//
// Ports:
//   clk        sole clock, all state on posedge
//   reset      synchronous, active-high
//   start      single-cycle pulse, begins a frame (from IDLE or DONE)
//   s_valid    upstream sample valid
//   s_data     upstream sample, passed unmodified
//   s_ready    loader accepts a sample this cycle (decoded from state only)
//   mem_we     data-memory write enable, one cycle per accepted sample
//   mem_a      data-memory byte address
//   mem_wd     data-memory write data, {16'h0000, sample}
//   busy       frame in progress (LOAD or LAST)
//   done       frame fully written (level, held until next start)
//   count      samples accepted in the current frame
//   start_err  sticky: start seen while busy, cleared only by reset
// ----------------------------------------------------------------------------
module fft_sample_loader #(
    parameter int          N_LOG2    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              s_valid,
    input  logic [15:0]       s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [31:0]       mem_a,
    output logic [31:0]       mem_wd,
    output logic              busy,
    output logic              done,
    output logic [N_LOG2:0]   count,
    output logic              start_err
);

    localparam int            N        = 1 << N_LOG2;
    localparam logic [N_LOG2:0] LAST_CNT = (N_LOG2 + 1)'(N - 1);

    typedef enum logic [1:0] {IDLE, LOAD, LAST, DONE} state_t;

    state_t            state, state_nxt;
    logic              xfer;
    logic              restart;
    logic [N_LOG2-1:0] idx;
    logic [31:0]       offset;

    // s_ready comes purely from the state register, so a transfer is just
    // LOAD qualified by s_valid.
    assign xfer    = (state == LOAD) && s_valid;
    assign restart = start && ((state == IDLE) || (state == DONE));

    always_comb begin
        idx = '0;
`ifdef FFT_LOADER_BITREV_EN
        for (int i = 0; i < N_LOG2; i++) begin
            idx[i] = count[N_LOG2-1-i];
        end
`else
        idx = count[N_LOG2-1:0];
`endif
    end

    // Half-word index to byte offset.
    assign offset = {{(31 - N_LOG2){1'b0}}, idx, 1'b0};

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (xfer && (count == LAST_CNT)) state_nxt = LAST;
            end
            LAST: begin
                // Final write is on the memory port this cycle.
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    // mem_a / mem_wd change only on a transfer; reset discards any transfer
    // in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_we    <= 1'b0;
            mem_a     <= BASE_ADDR;
            mem_wd    <= 32'h0;
            count     <= '0;
            start_err <= 1'b0;
        end else begin
            mem_we <= xfer;
            if (xfer) begin
                mem_a  <= BASE_ADDR + offset;
                mem_wd <= {16'h0000, s_data};
                count  <= count + 1'b1;
            end else if (restart) begin
                count  <= '0;
            end
            if (start && busy) start_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fft_sample_loader.sv
module tb_fft_sample_loader;
    localparam int          NL   = 8;
    localparam int          N    = 1 << NL;
    localparam logic [31:0] BASE = 32'h0000_0200;

    logic        clk = 1'b0;
    logic        reset, start, s_valid;
    logic [15:0] s_data;
    logic        s_ready, mem_we, busy, done, start_err;
    logic [31:0] mem_a, mem_wd;
    logic [NL:0] count;

    fft_sample_loader #(.N_LOG2(NL), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .start(start), .s_valid(s_valid),
        .s_data(s_data), .s_ready(s_ready), .mem_we(mem_we), .mem_a(mem_a),
        .mem_wd(mem_wd), .busy(busy), .done(done), .count(count),
        .start_err(start_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: a frame is "loading" until N samples were taken, then
    // one cycle with the last write on the port, then done.
    bit          loading, in_last, m_done, m_err;
    int          k;
    bit          exp_we;
    logic [31:0] exp_a, exp_wd;
    logic [15:0] exp_mem [N];
    logic [15:0] got_mem [N];
    int          nwrites;

    function automatic int idx_of(int c);
        int r;
        r = 0;
`ifdef FFT_LOADER_BITREV_EN
        for (int b = 0; b < NL; b++)
            if (((c >> b) & 1) != 0) r = r | (1 << (NL - 1 - b));
`else
        r = c % N;
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Apply inputs for the next edge and predict the outcome.
    task automatic drive(input bit v, input logic [15:0] d, input bit st, input bit rs);
        bit bb;
        s_valid = v; s_data = d; start = st; reset = rs;
        exp_we = 1'b0;
        if (rs) begin
            loading = 0; in_last = 0; m_done = 0; m_err = 0; k = 0;
            exp_a = BASE; exp_wd = 32'h0;
        end else begin
            bb = loading || in_last;
            if (in_last) begin in_last = 0; m_done = 1; end
            if (v && loading) begin
                exp_we = 1'b1;
                exp_a  = BASE + 32'(2 * idx_of(k));
                exp_wd = {16'h0000, d};
                exp_mem[idx_of(k)] = d;
                k++;
                if (k == N) begin loading = 0; in_last = 1; end
            end
            if (st) begin
                if (bb) m_err = 1;
                else begin loading = 1; k = 0; m_done = 0; end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        chk("mem_we", 64'(mem_we), 64'(exp_we));
        chk("mem_a", 64'(mem_a), 64'(exp_a));
        chk("mem_wd", 64'(mem_wd), 64'(exp_wd));
        chk("s_ready", 64'(s_ready), 64'(loading));
        chk("busy", 64'(busy), 64'(loading || in_last));
        chk("done", 64'(done), 64'(m_done));
        chk("count", 64'(count), 64'(k));
        chk("start_err", 64'(start_err), 64'(m_err));
        if (mem_we === 1'b1) begin
            got_mem[((mem_a - BASE) >> 1) % N] = mem_wd[15:0];
            nwrites++;
        end
    endtask

    task automatic clear_mems();
        for (int i = 0; i < N; i++) begin
            exp_mem[i] = 16'hxxxx; got_mem[i] = 16'hdead;
        end
        nwrites = 0;
    endtask

    task automatic check_mems(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < N; i++)
            if (got_mem[i] !== exp_mem[i]) bad++;
        chk({tag, "_mem_words_bad"}, 64'(bad), 64'd0);
        chk({tag, "_nwrites"}, 64'(nwrites), 64'(N));
    endtask

    // One frame: start, then samples until N accepted or reset.
    // gaps: random s_valid; err_at: pulse start alongside sample n;
    // rst_at: reset alongside sample n (with s_valid=1).
    task automatic run_frame(input bit gaps, input bit seq_data, input int err_at, input int rst_at);
        int n;
        bit v, st, rs;
        logic [15:0] d;
        clear_mems();
        drive(0, 16'h0, 1, 0); cycle();
        n = 0;
        for (int g = 0; g < 4000 && n < N; g++) begin
            v  = gaps ? bit'($urandom_range(0, 1)) : 1'b1;
            if (n == rst_at) v = 1'b1;
            d  = seq_data ? 16'(n) : 16'($urandom);
            if (n == 7) d = 16'h8001;
            st = v && (n == err_at);
            rs = v && (n == rst_at);
            drive(v, d, st, rs); cycle();
            if (rs) return;
            if (v) n++;
        end
        chk("frame_complete", 64'(n), 64'(N));
        // Tail: LAST then DONE.
        drive(0, 16'h0, 0, 0); cycle();
        drive(0, 16'h0, 0, 0); cycle();
        drive(1, 16'h1234, 0, 0); cycle();
    endtask

    initial begin
        clear_mems();
        drive(0, 16'h0, 0, 1); cycle();
        drive(1, 16'hffff, 0, 1); cycle();
        // Idle with s_valid high: nothing accepted.
        for (int i = 0; i < 5; i++) begin drive(1, 16'(i), 0, 0); cycle(); end

        // Back-to-back 0..N-1.
        run_frame(0, 1, -1, -1);
        check_mems("seq");
        chk("seq_w1", 64'(got_mem[idx_of(1)]), 64'h1);
        chk("seq_w3", 64'(got_mem[idx_of(3)]), 64'h3);

        // Random gaps, start pulsed at sample 100, restart from DONE.
        run_frame(1, 0, 100, -1);
        check_mems("gaps");

        // Start coincident with the final transfer.
        run_frame(1, 0, N - 1, -1);
        check_mems("startlast");

        // Reset with a transfer at sample 37.
        run_frame(1, 0, -1, 37);
        for (int i = 0; i < 3; i++) begin drive(1, 16'h5555, 0, 0); cycle(); end

        // Fresh frame after reset.
        run_frame(0, 0, -1, -1);
        check_mems("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fft_sample_loader.md
# fft_sample_loader

Streams 16-bit FFT input samples into the MCU data memory before an FFT run. Accepts samples on a valid/ready handshake and drives the data memory write port (`we`, `a`, `wd`) with one 16-bit half-word per sample. Sample *k* lands at half-word index `rev(k)` (bit-reversed) or `k`, so the FFT core can run in-place. Sits directly upstream of the data memory, muxed onto its write port while the core is held off.

## Interface
Parameters:
- `N_LOG2`, 8, log2 of samples per frame (frame length N = 2^N_LOG2; 8 → 256 half-words, matching memory depth)
- `BASE_ADDR`, 32'h0000_0000, byte address of half-word index 0

Ports:
- `clk`  in  1  sole clock, all state on posedge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  single-cycle pulse, begins a frame
- `s_valid`  in  1  upstream sample valid
- `s_data`  in  16  upstream sample (two's complement, passed unmodified)
- `s_ready`  out  1  loader can accept a sample this cycle
- `mem_we`  out  1  data-memory write enable
- `mem_a`  out  32  data-memory byte address
- `mem_wd`  out  32  data-memory write data, `{16'h0000, sample}`
- `busy`  out  1  frame in progress
- `done`  out  1  frame fully written, level
- `count`  out  N_LOG2+1  samples accepted in current frame
- `start_err`  out  1  sticky: `start` seen while busy

## Operation
- FSM states: IDLE, LOAD, LAST, DONE.
- IDLE: `start` → LOAD; `count` ← 0.
- LOAD: `s_ready`=1. Transfer occurs when `s_valid && s_ready`. Each transfer:
  - registers the write, `mem_we`=1 next cycle;
  - `count` += 1.
  - The transfer with `count`==N-1 → LAST.
- LAST: `s_ready`=0; the final write is on the memory port this cycle → DONE next cycle.
- DONE: `done`=1, `s_ready`=0; `start` → LOAD with `count` ← 0, `done` ← 0.
- `busy` = state ∈ {LOAD, LAST}.
- `start` in LOAD or LAST: ignored for FSM; sets `start_err`, which is cleared only by `reset`.
- Address:
  - idx = `count[N_LOG2-1:0]` at transfer time, optionally bit-reversed (see Configuration);
  - `mem_a` = `BASE_ADDR` + {idx, 1'b0}, 32-bit modular add. Memory ignores bit 0 and indexes with `a[8:1]`.
- `mem_a` and `mem_wd` are registered and change only on a transfer; they hold their last value otherwise.
- `mem_we` is 1 for exactly one cycle per transfer.

## Timing
- Reset values: state IDLE, `s_ready`=0, `mem_we`=0, `mem_a`=`BASE_ADDR`, `mem_wd`=0, `busy`=0, `done`=0, `count`=0, `start_err`=0.
- `s_ready` is decoded from the state register only, with no combinational path from `s_valid`.
- Latency is 1 cycle from transfer edge to `mem_we`; the memory commits on the following posedge.
- Back-to-back transfers sustain 1 sample/cycle, and `mem_we` stays high continuously.
- `start` edge → `s_ready`=1 in the next cycle.
- Transfer of sample N-1 at cycle t:
  - `mem_we` for it at t+1 (state LAST);
  - `done`=1 from t+2.
  - When `done` is observed, all N words are committed.
- `s_valid` low stalls with no penalty; `s_data` is sampled only on a transfer.
- Reset mid-frame, the same cycle as a transfer: the transfer is discarded, `mem_we`=0 next cycle, and the frame is abandoned.
- `start` in the same cycle as the final transfer: that transfer completes, `start_err` is set, and the frame still ends.

## Configuration
- `FFT_LOADER_BITREV_EN` defined:
  - idx = bit-reverse of `count[N_LOG2-1:0]` over N_LOG2 bits;
  - the frame lands in memory pre-permuted for an in-place DIT FFT.
- Undefined: idx = `count` (natural order); the FFT core performs its own reordering.

## Test plan
- Reset, then idle 5 cycles → all outputs at reset values; `s_ready`=0 even with `s_valid`=1.
- `start`, then 256 back-to-back samples 0x0000..0x00FF:
  - natural order: memory half-word k = k;
  - with `FFT_LOADER_BITREV_EN`: sample 1 (0x0001) at `mem_a`=0x100 (idx 0x80), sample 3 at idx 0xC0;
  - `done` rises 2 cycles after the last transfer; `count`=256.
- Random `s_valid` gaps (~50% duty), `BASE_ADDR`=32'h0000_0200 → exactly 256 `mem_we` pulses, first `mem_a`=0x200, no duplicate or missing writes.
- `start` pulsed at sample 100 → `start_err`=1; frame unaffected and completes at 256; second `start` from DONE clears `done` and restarts at `count`=0.
- `reset` asserted with `s_valid`=1 mid-frame (sample 37) → next cycle `mem_we`=0, state IDLE, `count`=0, `start_err`=0.
- Negative sample 16'h8001 → `mem_wd`=32'h0000_8001 (no sign extension).
